// File: rtl/mmio_bridge.sv
// mmio_bridge: splits core byte-bus cycles between block RAM and a small I/O
// window at 0x3xxxx holding an RX FIFO, a TX FIFO and a free-running cycle
// counter. Read data is returned one cycle after the address.
module mmio_bridge #(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_stall,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_we,
  input  logic [7:0]  ram_din,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        rx_overflow,
  output logic        prog_done
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_PTR_ONE = {{RX_AW{1'b0}}, 1'b1};
  localparam logic [TX_AW:0] TX_PTR_ONE = {{TX_AW{1'b0}}, 1'b1};

  // Address decode and access qualification
  logic is_io_s;
  logic acc_s;
  logic io_rd_s;
  logic io_wr_s;
  logic addr_data_s;   // 0x30000: RX pop on read, TX push on write
  logic addr_cnt_s;    // 0x30004..0x30007: counter snapshot bytes
  logic addr_prog_s;   // 0x30004 exactly: program-stop on write
  logic unused_addr_s;

  assign is_io_s     = (cpu_a[17:16] == 2'b11);
  assign acc_s       = rdy_in;
  assign io_rd_s     = acc_s & ~cpu_wr & is_io_s;
  assign io_wr_s     = acc_s & cpu_wr & is_io_s;
  assign addr_data_s = (cpu_a[15:0] == 16'h0000);
  assign addr_cnt_s  = (cpu_a[15:2] == 14'h0001);
  assign addr_prog_s = (cpu_a[15:0] == 16'h0004);
  assign unused_addr_s = ^cpu_a[31:18];

  // RAM side passes straight through
  assign ram_a    = cpu_a[16:0];
  assign ram_dout = cpu_dout;
  assign ram_we   = cpu_wr & ~is_io_s & rdy_in;

  // ---------------- RX FIFO ----------------
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW:0]   rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RX_AW:0]   rx_rd_ptr_q, rx_rd_ptr_d;
  logic             rx_empty_s, rx_full_s, rx_pop_s, rx_push_s;
  logic [7:0]       rx_head_s;
  logic             rx_overflow_q, rx_overflow_d;

  assign rx_empty_s = (rx_wr_ptr_q == rx_rd_ptr_q);
  assign rx_full_s  = (rx_wr_ptr_q[RX_AW] != rx_rd_ptr_q[RX_AW]) &&
                      (rx_wr_ptr_q[RX_AW-1:0] == rx_rd_ptr_q[RX_AW-1:0]);
  assign rx_head_s  = rx_mem_q[rx_rd_ptr_q[RX_AW-1:0]];
  assign rx_pop_s   = io_rd_s & addr_data_s & ~rx_empty_s;
  // A pop in the same cycle frees the slot, so a push on full still lands
  assign rx_push_s  = rx_valid & (~rx_full_s | rx_pop_s);

  // RX pointer and overflow next-state
  always_comb begin
    rx_wr_ptr_d   = rx_wr_ptr_q;
    rx_rd_ptr_d   = rx_rd_ptr_q;
    rx_overflow_d = rx_overflow_q;
    if (rx_push_s) begin
      rx_wr_ptr_d = rx_wr_ptr_q + RX_PTR_ONE;
    end else begin
      rx_wr_ptr_d = rx_wr_ptr_q;
    end
    if (rx_pop_s) begin
      rx_rd_ptr_d = rx_rd_ptr_q + RX_PTR_ONE;
    end else begin
      rx_rd_ptr_d = rx_rd_ptr_q;
    end
    if (rx_valid && !rx_push_s) begin
      rx_overflow_d = 1'b1;
    end else begin
      rx_overflow_d = rx_overflow_q;
    end
  end

  // RX storage write (contents are don't-care until pointed at)
  always_ff @(posedge clk_in) begin
    if (rx_push_s) begin
      rx_mem_q[rx_wr_ptr_q[RX_AW-1:0]] <= rx_data;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [TX_AW:0]   tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TX_AW:0]   tx_rd_ptr_q, tx_rd_ptr_d;
  logic             tx_empty_s, tx_full_s, tx_pop_s, tx_push_req_s, tx_push_s;
  logic [7:0]       tx_push_data_s;
  logic             prog_done_q, prog_done_d;

  assign tx_empty_s = (tx_wr_ptr_q == tx_rd_ptr_q);
  assign tx_full_s  = (tx_wr_ptr_q[TX_AW] != tx_rd_ptr_q[TX_AW]) &&
                      (tx_wr_ptr_q[TX_AW-1:0] == tx_rd_ptr_q[TX_AW-1:0]);
  assign tx_pop_s   = ~tx_empty_s & tx_ready;
  // Zero bytes written to the data port are swallowed; the program-stop
  // write always queues a 0x00 so the host sees the end marker.
  assign tx_push_req_s  = io_wr_s & ((addr_data_s & (cpu_dout != 8'h00)) | addr_prog_s);
  assign tx_push_data_s = addr_data_s ? cpu_dout : 8'h00;
  assign tx_push_s      = tx_push_req_s & (~tx_full_s | tx_pop_s);

  // TX pointer and program-stop next-state
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    prog_done_d = prog_done_q;
    if (tx_push_s) begin
      tx_wr_ptr_d = tx_wr_ptr_q + TX_PTR_ONE;
    end else begin
      tx_wr_ptr_d = tx_wr_ptr_q;
    end
    if (tx_pop_s) begin
      tx_rd_ptr_d = tx_rd_ptr_q + TX_PTR_ONE;
    end else begin
      tx_rd_ptr_d = tx_rd_ptr_q;
    end
    if (io_wr_s && addr_prog_s) begin
      prog_done_d = 1'b1;
    end else begin
      prog_done_d = prog_done_q;
    end
  end

  // TX storage write
  always_ff @(posedge clk_in) begin
    if (tx_push_s) begin
      tx_mem_q[tx_wr_ptr_q[TX_AW-1:0]] <= tx_push_data_s;
    end
  end

  // ---------------- Counter and read return ----------------
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cnt_snap_q, cnt_snap_d;
  logic [7:0]  io_rdata_q, io_rdata_d;
  logic        sel_io_q, sel_io_d;

  assign cnt_d = cnt_q + 32'd1;

  // I/O read data, counter snapshot and return-path select
  always_comb begin
    io_rdata_d = io_rdata_q;
    cnt_snap_d = cnt_snap_q;
    sel_io_d   = sel_io_q;
    if (acc_s && !cpu_wr) begin
      sel_io_d = is_io_s;
      if (is_io_s && addr_data_s) begin
        io_rdata_d = rx_empty_s ? 8'h00 : rx_head_s;
      end else if (is_io_s && addr_cnt_s) begin
        case (cpu_a[1:0])
          2'b00: begin
            cnt_snap_d = cnt_q;
            io_rdata_d = cnt_q[7:0];
          end
          2'b01:   io_rdata_d = cnt_snap_q[15:8];
          2'b10:   io_rdata_d = cnt_snap_q[23:16];
          2'b11:   io_rdata_d = cnt_snap_q[31:24];
          default: io_rdata_d = 8'h00;
        endcase
      end else if (is_io_s) begin
        io_rdata_d = 8'h00;
      end else begin
        io_rdata_d = io_rdata_q;
      end
    end else begin
      sel_io_d = sel_io_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
      rx_overflow_q <= 1'b0;
      prog_done_q   <= 1'b0;
      cnt_q         <= 32'h0000_0000;
      cnt_snap_q    <= 32'h0000_0000;
      io_rdata_q    <= 8'h00;
      sel_io_q      <= 1'b0;
    end else begin
      rx_wr_ptr_q   <= rx_wr_ptr_d;
      rx_rd_ptr_q   <= rx_rd_ptr_d;
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
      rx_overflow_q <= rx_overflow_d;
      prog_done_q   <= prog_done_d;
      cnt_q         <= cnt_d;
      cnt_snap_q    <= cnt_snap_d;
      io_rdata_q    <= io_rdata_d;
      sel_io_q      <= sel_io_d;
    end
  end

  assign cpu_din     = sel_io_q ? io_rdata_q : ram_din;
  assign io_stall    = tx_full_s;
  assign tx_valid    = ~tx_empty_s;
  assign tx_data     = tx_mem_q[tx_rd_ptr_q[TX_AW-1:0]];
  assign rx_overflow = rx_overflow_q;
  assign prog_done   = prog_done_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: read and TX expectations are queued when
// stimulus is driven and checked when the bridge produces the byte.
module tb_mmio_bridge;

  logic        clk_in, rst_in, rdy_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        io_stall;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        rx_overflow;
  logic        prog_done;

  int checks;
  int failures;

  logic [7:0]  rd_exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic        rd_flag;
  logic        rd_check_q;
  logic [31:0] edges;
  logic [31:0] snap;
  logic [7:0]  ram_mem [0:131071];

  mmio_bridge #(.RX_DEPTH(8), .TX_DEPTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .io_stall(io_stall), .ram_a(ram_a), .ram_dout(ram_dout), .ram_we(ram_we),
    .ram_din(ram_din), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_overflow(rx_overflow), .prog_done(prog_done)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Block RAM model with one cycle of read latency
  always @(posedge clk_in) begin
    if (ram_we) ram_mem[ram_a] <= ram_dout;
    ram_din <= ram_mem[ram_a];
  end

  // Reference count of rising edges since reset release
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) edges <= 32'd0;
    else         edges <= edges + 32'd1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Read data is due the cycle after the address
  always @(posedge clk_in) rd_check_q <= rd_flag;

  // Read-return checker
  always @(negedge clk_in) begin
    if (rd_check_q) begin
      if (rd_exp_q.size() == 0) check_val("rd_unexpected", 32'd1, 32'd0);
      else check_val("cpu_din", {24'd0, cpu_din}, {24'd0, rd_exp_q.pop_front()});
    end
  end

  // TX byte checker
  always @(negedge clk_in) begin
    if (tx_valid && tx_ready) begin
      if (tx_exp_q.size() == 0) check_val("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
      else check_val("tx_data", {24'd0, tx_data}, {24'd0, tx_exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_idle();
    cpu_a = 32'd0; cpu_wr = 1'b0; cpu_dout = 8'h00; rdy_in = 1'b1; rd_flag = 1'b0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [7:0] d);
    cpu_a = {14'd0, a}; cpu_dout = d; cpu_wr = 1'b1; rdy_in = 1'b1;
    #1;
    check_val("ram_we", {31'd0, ram_we}, {31'd0, (a[17:16] != 2'b11)});
    @(posedge clk_in);
    #1;
    bus_idle();
  endtask

  task automatic do_read(input logic [17:0] a, input logic [7:0] exp);
    cpu_a = {14'd0, a}; cpu_wr = 1'b0; rdy_in = 1'b1; rd_flag = 1'b1;
    rd_exp_q.push_back(exp);
    tick();
    bus_idle();
  endtask

  task automatic rx_strobe(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_in = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    bus_idle();
    #23;
    check_val("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_val("rst_io_stall", {31'd0, io_stall}, 32'd0);
    check_val("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check_val("rst_rx_overflow", {31'd0, rx_overflow}, 32'd0);
    check_val("rst_prog_done", {31'd0, prog_done}, 32'd0);
    @(negedge clk_in) rst_in = 1'b1;
    tick();

    // RAM pass-through, including the top of the 128 KB range
    do_write(18'h00000, 8'hC3);
    do_write(18'h00010, 8'hA5);
    #1 check_val("ram_we_idle", {31'd0, ram_we}, 32'd0);
    do_read(18'h00010, 8'hA5);
    do_write(18'h1FFFF, 8'h5A);
    do_read(18'h1FFFF, 8'h5A);
    do_read(18'h00010, 8'hA5);

    // RX FIFO: two bytes, third read of an empty FIFO returns 0
    rx_strobe(8'h41);
    rx_strobe(8'h42);
    do_read(18'h30000, 8'h41);
    do_read(18'h30000, 8'h42);
    do_read(18'h30000, 8'h00);

    // TX: zero byte is swallowed
    tx_ready = 1'b1;
    tx_exp_q.push_back(8'h48); do_write(18'h30000, 8'h48);
    do_write(18'h30000, 8'h00);
    tx_exp_q.push_back(8'h49); do_write(18'h30000, 8'h49);
    repeat (4) tick();
    check_val("tx_drain1", tx_exp_q.size(), 32'd0);

    // TX full: stall after the 8th push, 9th byte dropped
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_exp_q.push_back(8'h61 + 8'(i));
      do_write(18'h30000, 8'h61 + 8'(i));
      if (i == 6) check_val("stall_7th", {31'd0, io_stall}, 32'd0);
      if (i == 7) check_val("stall_8th", {31'd0, io_stall}, 32'd1);
    end
    check_val("stall_9th", {31'd0, io_stall}, 32'd1);
    tx_ready = 1'b1;
    tick();
    check_val("stall_release", {31'd0, io_stall}, 32'd0);
    repeat (10) tick();
    check_val("tx_drain2", tx_exp_q.size(), 32'd0);

    // rdy_in low: no pop, read return holds, no RAM write
    rx_strobe(8'h11);
    rx_strobe(8'h22);
    do_read(18'h30000, 8'h11);
    rdy_in = 1'b0; cpu_a = 32'h0003_0000;
    tick();
    check_val("rdy_hold_din", {24'd0, cpu_din}, 32'h11);
    cpu_a = 32'h0000_0020; cpu_wr = 1'b1; cpu_dout = 8'hEE;
    #1 check_val("rdy_ram_we", {31'd0, ram_we}, 32'd0);
    tick();
    bus_idle();
    do_read(18'h30000, 8'h22);
    do_read(18'h30001, 8'h00);
    do_read(18'h30010, 8'h00);

    // Program-stop write queues 0x00 and latches prog_done
    do_write(18'h30008, 8'h77);
    tx_exp_q.push_back(8'h00);
    do_write(18'h30004, 8'hFF);
    check_val("prog_done_set", {31'd0, prog_done}, 32'd1);
    repeat (4) tick();
    check_val("prog_done_sticky", {31'd0, prog_done}, 32'd1);
    check_val("tx_drain3", tx_exp_q.size(), 32'd0);

    // RX overflow on the 9th strobe
    for (int i = 0; i < 8; i++) rx_strobe(8'h80 + 8'(i));
    check_val("rx_ovf_8", {31'd0, rx_overflow}, 32'd0);
    rx_strobe(8'h88);
    check_val("rx_ovf_9", {31'd0, rx_overflow}, 32'd1);
    do_read(18'h30000, 8'h80);
    do_read(18'h30000, 8'h81);
    tx_ready = 1'b0;
    do_write(18'h30000, 8'h33);
    check_val("tx_pending", {31'd0, tx_valid}, 32'd1);

    // Asynchronous reset between clock edges discards everything
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    check_val("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_val("arst_io_stall", {31'd0, io_stall}, 32'd0);
    check_val("arst_rx_overflow", {31'd0, rx_overflow}, 32'd0);
    check_val("arst_prog_done", {31'd0, prog_done}, 32'd0);
    check_val("arst_din_path", {24'd0, cpu_din}, {24'd0, ram_din});
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    tx_ready = 1'b1;

    // Counter snapshot after 100 edges; later byte reads use the snapshot
    repeat (100) @(posedge clk_in);
    #1;
    check_val("edges_100", edges, 32'd100);
    snap = edges;
    do_read(18'h30004, snap[7:0]);
    repeat (5) tick();
    do_read(18'h30005, snap[15:8]);
    repeat (3) tick();
    do_read(18'h30006, snap[23:16]);
    do_read(18'h30007, snap[31:24]);
    do_read(18'h30000, 8'h00);
    repeat (300) tick();
    snap = edges;
    do_read(18'h30004, snap[7:0]);
    repeat (7) tick();
    do_read(18'h30005, snap[15:8]);

    repeat (4) tick();
    check_val("rd_queue_empty", rd_exp_q.size(), 32'd0);
    check_val("tx_queue_empty", tx_exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Memory-side bus decoder between the `cpu` byte bus and the 128 KB block RAM / UART. Splits each cycle's access by `mem_a[17:16]`. RAM accesses pass through. I/O accesses at 0x30000/0x30004 are served from an RX FIFO, a TX FIFO and a free-running cycle counter. Read data returns one cycle after the address, matching the 2-cycle read contract the core already relies on.

## Interface
- `RX_DEPTH`, 8: RX FIFO entries (power of 2, ≥2).
- `TX_DEPTH`, 8: TX FIFO entries (power of 2, ≥2).
- `clk_in` in 1: the single clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `rdy_in` in 1: global ready; when low, no FIFO push/pop from the core side, counter still runs.
- `cpu_a` in 32: core address (only [17:0] decoded).
- `cpu_dout` in 8: core write data.
- `cpu_wr` in 1: 1 = write, 0 = read.
- `cpu_din` out 8: read data to core, valid the cycle after the address.
- `io_stall` out 1: high while TX FIFO full; the top ANDs its inverse into the core's `rdy_in`.
- `ram_a` out 17: RAM address = `cpu_a[16:0]`.
- `ram_dout` out 8: RAM write data.
- `ram_we` out 1: RAM write enable.
- `ram_din` in 8: RAM read data, registered inside RAM (1-cycle latency).
- `rx_data` in 8: UART received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `tx_data` out 8: byte to UART transmitter.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: transmitter accepts when high with `tx_valid`.
- `rx_overflow` out 1: sticky, byte dropped on full RX FIFO.
- `prog_done` out 1: sticky, program-stop write seen.

## Operation
- Decode: `is_io = cpu_a[17:16]==2'b11`. Otherwise RAM. `ram_we = cpu_wr & ~is_io & rdy_in`.
- Access qualifier `acc = rdy_in`. Each qualified cycle is exactly one access; the core holds an address for one cycle per byte.
- Cycle counter: 32-bit, +1 every clock from reset release, wraps at 0xFFFF_FFFF→0.
- Read 0x30000: if RX non-empty, pop the head byte into `io_rdata_q`; if empty, `io_rdata_q`=0x00 and no pop.
- Read 0x30004: snapshot the counter into `cnt_snap`; return byte 0. Reads of 0x30005/6/7 return `cnt_snap` bytes 1/2/3 (little-endian) with no new snapshot.
- Read of any other I/O address: returns 0x00, no side effects.
- Write 0x30000: push `cpu_dout` to TX if nonzero. A 0x00 write is ignored.
- Write 0x30004: push 0x00 to TX and set `prog_done`.
- Other I/O writes are ignored.
- Push to a full TX FIFO is dropped. The core must honour `io_stall`.
- Read return: register `sel_io_q <= is_io` on every qualified read. `cpu_din = sel_io_q ? io_rdata_q : ram_din`.
- RX push: on `rx_valid`. When full, drop the byte and set `rx_overflow`. Simultaneous push and pop on a full FIFO: pop first, push succeeds.
- TX drain: `tx_valid = ~tx_empty`, `tx_data` = head. Pop on `tx_valid & tx_ready`. Simultaneous push and pop on a full TX FIFO: both happen, and the count stays full.
- FIFOs: circular, pointers one bit wider than the index; full when MSBs differ and the rest are equal.

## Timing
- Reset (`rst_in`=0, async) clears:
  - all FIFO pointers, counter, `cnt_snap`, `io_rdata_q`, `sel_io_q`
  - `rx_overflow`, `prog_done`
  - outputs: `cpu_din`=`ram_din` path (sel 0), `tx_valid`=0, `io_stall`=0, `ram_we`=0.
- Reset asserted mid-transfer discards FIFO contents; no partial byte is emitted.
- Read latency: address at cycle N, data on `cpu_din` during N+1. Writes take effect at the end of cycle N.
- RX byte strobed at N is poppable by a read at N+1.
- TX byte written at N shows `tx_valid` at N+1.
- `io_stall` rises the cycle after the push that fills TX. It falls the cycle after a pop from full.
- Counter value snapshotted at N equals the number of rising edges since reset release, up to and including edge N-1.
- `rdy_in`=0: no pushes or pops from the core side, `sel_io_q`/`io_rdata_q` hold, UART side continues.

## Test plan
- RAM write 0xA5 to 0x00010, then read 0x00010 → `ram_we`=1 for one cycle; `cpu_din`=0xA5 the cycle after the read address.
- Strobe `rx_data` 0x41, 0x42, then read 0x30000 three times → returns 0x41, 0x42, 0x00; RX empty.
- Write 0x48, 0x00, 0x49 to 0x30000 with `tx_ready`=1 → `tx_data` emits 0x48, 0x49 only.
- Hold `tx_ready`=0 and write 9 bytes → `io_stall`=1 after the 8th; the 9th is dropped; release `tx_ready` → 8 bytes out in order.
- Reset, wait 100 clocks, read 0x30004..0x30007 → bytes form 100 (±pipeline offset per Timing), little-endian; later byte reads are unaffected by the running counter.
- Write 0x30004 → `prog_done`=1 sticky; TX emits 0x00. Overflow RX with 9 strobes → `rx_overflow`=1. Assert `rst_in`=0 → all clear asynchronously.
